booth_seq_ctrl: RTL and testbench

Sequential radix-2 Booth multiplier: an FSM-driven add/subtract/shift datapath that computes one signed `width`×`width` product over `width` clock cycles. It uses a start/busy/done handshake and holds the result in a register. It is the area-reduced, clocked counterpart of the combinational `booth` multiplier. Results are bit-identical to `booth` for every operand pair, including the most-negative operand.

---
 rtl/booth_seq_ctrl_if.sv | 21 ++
 rtl/booth_seq_ctrl.sv | 80 ++++++++
 tb/tb_booth_seq_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/booth_seq_ctrl_if.sv
// Start/busy/done handshake and operand/result bus for the sequential Booth multiplier.
interface booth_seq_ctrl_if #(
    parameter int width = 6
);
    logic                  start;
    logic [width-1:0]      in1;
    logic [width-1:0]      in2;
    logic                  busy;
    logic                  done;
    logic [2*width-1:0]    out;

    modport master (
        output start, in1, in2,
        input  busy, done, out
    );

    modport slave (
        input  start, in1, in2,
        output busy, done, out
    );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier: one signed width x width product over width cycles,
// start/busy/done handshake, registered result held until the next completion.
module booth_seq_ctrl #(
    parameter int width = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    booth_seq_ctrl_if.slave       bus
);
    localparam int CW = $clog2(width + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [width:0]     a;
    logic [width:0]     m;
    logic [width-1:0]   q;
    logic               q_1;
    logic [CW-1:0]      count;
    logic [2*width-1:0] out_r;

    logic [width:0]     a_sel;
    logic [width:0]     a_nxt;
    logic [width-1:0]   q_nxt;
    logic               accept;

    assign accept = bus.start && (state != S_CALC);

    // A carries one guard bit so subtracting M = -2^(width-1) cannot overflow.
    always_comb begin
        a_sel = a;
        unique case ({q[0], q_1})
            2'b01:   a_sel = a + m;
            2'b10:   a_sel = a - m;
            default: a_sel = a;
        endcase
        a_nxt = {a_sel[width], a_sel[width:1]};
        q_nxt = {a_sel[0], q[width-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a     <= '0;
            m     <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            count <= '0;
            out_r <= '0;
        end else if (accept) begin
            state <= S_CALC;
            m     <= {bus.in1[width-1], bus.in1};
            q     <= bus.in2;
            a     <= '0;
            q_1   <= 1'b0;
            count <= CW'(width);
        end else begin
            unique case (state)
                S_CALC: begin
                    a     <= a_nxt;
                    q     <= q_nxt;
                    q_1   <= q[0];
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        out_r <= {a_nxt[width-1:0], q_nxt};
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = (state == S_CALC);
    assign bus.done = (state == S_DONE);
    assign bus.out  = out_r;
endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed and exhaustive checks of booth_seq_ctrl at width 6, including handshake corner cases.
module tb_booth_seq_ctrl;
    localparam int W = 6;

    typedef struct {
        int         a;
        int         b;
        logic [11:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs [8];

    booth_seq_ctrl_if #(.width(W)) bus ();

    booth_seq_ctrl #(.width(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // One complete operation: checks busy length, done arrival, result and done width.
    task automatic run_op(input int a, input int b, input logic [11:0] exp, input string nm);
        int bc;
        bit got;
        @(negedge clk);
        bus.in1   = W'(a);
        bus.in2   = W'(b);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bc  = 0;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (bus.done) got = 1;
            else begin
                if (bus.busy) bc++;
                @(negedge clk);
            end
        end
        chk({nm, " done_seen"}, 32'(got), 32'd1);
        chk({nm, " busy_cycles"}, 32'(bc), 32'(W));
        chk({nm, " out"}, 32'(bus.out), 32'(exp));
        @(negedge clk);
        chk({nm, " done_one_cycle"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int bc;
        int dc;
        int cyc;
        int t1;
        int t2;
        int phase;
        logic [11:0] o;

        checks = 0;
        errors = 0;

        vecs[0] = '{a:   3, b:  -5, exp: 12'hFF1};
        vecs[1] = '{a: -32, b: -32, exp: 12'h400};
        vecs[2] = '{a: -32, b:  31, exp: 12'hC20};
        vecs[3] = '{a:  31, b:  31, exp: 12'h3C1};
        vecs[4] = '{a:   0, b: -32, exp: 12'h000};
        vecs[5] = '{a:  -1, b:  -1, exp: 12'h001};
        vecs[6] = '{a:   1, b: -32, exp: 12'hFE0};
        vecs[7] = '{a:  31, b: -32, exp: 12'hC20};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.in1   = '0;
        bus.in2   = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset out", 32'(bus.out), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        for (int i = -32; i < 32; i++)
            for (int j = -32; j < 32; j++)
                run_op(i, j, 12'(i * j), $sformatf("exh %0d*%0d", i, j));

        // Start and new operands during CALC must not disturb the running operation.
        @(negedge clk);
        bus.in1 = W'(7); bus.in2 = W'(9); bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.in1 = W'(1); bus.in2 = W'(1); bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bc = 0; dc = 0; o = '0;
        for (int k = 0; k < 20; k++) begin
            if (bus.busy) bc++;
            if (bus.done) begin dc++; o = bus.out; end
            @(negedge clk);
        end
        chk("calc_start busy_rest", 32'(bc), 32'd3);
        chk("calc_start done_count", 32'(dc), 32'd1);
        chk("calc_start out", 32'(o), 32'h03F);
        chk("calc_start out_held", 32'(bus.out), 32'h03F);

        // Asynchronous reset in the fourth CALC cycle discards the operation.
        bus.in1 = W'(10); bus.in2 = W'(-3); bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset busy", 32'(bus.busy), 32'd0);
        chk("midreset done", 32'(bus.done), 32'd0);
        chk("midreset out", 32'(bus.out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bc = 0; dc = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.busy) bc++;
            if (bus.done) dc++;
            @(negedge clk);
        end
        chk("midreset no_busy", 32'(bc), 32'd0);
        chk("midreset no_done", 32'(dc), 32'd0);
        run_op(10, -3, 12'hFE2, "post_reset");

        // Back-to-back: start held high through DONE picks up the new operands.
        bus.in1 = W'(5); bus.in2 = W'(5); bus.start = 1'b1;
        cyc = 0; t1 = -1; t2 = -1; phase = 0;
        for (int k = 0; k < 40 && phase < 3; k++) begin
            @(negedge clk);
            cyc++;
            if (bus.busy && bus.done) chk("b2b overlap", 32'd1, 32'd0);
            if (phase == 0 && bus.done) begin
                t1 = cyc;
                chk("b2b out1", 32'(bus.out), 32'h019);
                bus.in1 = W'(-6); bus.in2 = W'(7);
                phase = 1;
            end else if (phase == 1 && bus.busy) begin
                bus.start = 1'b0;
                phase = 2;
            end else if (phase == 2 && bus.done) begin
                t2 = cyc;
                chk("b2b out2", 32'(bus.out), 32'hFD6);
                phase = 3;
            end
        end
        chk("b2b completed", 32'(phase), 32'd3);
        chk("b2b spacing", 32'(t2 - t1), 32'd7);
        bus.start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
